// File: rtl/pmu_pkg.sv
// pmu_pkg: state encoding, default cycle counts and counter sizing for the power sequencer
package pmu_pkg;
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      OSC_ON    = 3'd1,
      RST_REL   = 3'd2,
      EFUSE     = 3'd3,
      ACTIVE    = 3'd4,
      STOP_CLK  = 3'd5,
      SHUT_HOLD = 3'd6
   } pmu_state_e;
   localparam int OSC_SETTLE_DEF = 16;
   localparam int EFUSE_TMO_DEF  = 64;
   localparam int SHUT_HOLD_DEF  = 4;
   localparam int FIFO_RST_DEF   = 2;
   function automatic int cnt_w(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      m = b > m ? b : m;
      m = c > m ? c : m;
      m = d > m ? d : m;
      return $clog2(m) + 1;
   endfunction
endpackage

// File: rtl/pmu_cnt.sv
// pmu_cnt: loadable down-counter that saturates at zero and flags it
module pmu_cnt #(
   parameter int W = 7
) (
   input  logic         clk_32k,
   input  logic         rst_32k_alon_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk_32k or negedge rst_32k_alon_n)
      if (!rst_32k_alon_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - W'(1);
   assign zero = cnt == '0;
endmodule

// File: rtl/pmu_seq.sv
// pmu_seq: always-on 32 kHz power-up/power-down sequencer driving CRGU clock enables and resets
module pmu_seq
   import pmu_pkg::*;
#(
   parameter int OSC_SETTLE_CYC = OSC_SETTLE_DEF,
   parameter int EFUSE_TMO_CYC  = EFUSE_TMO_DEF,
   parameter int SHUT_HOLD_CYC  = SHUT_HOLD_DEF,
   parameter int FIFO_RST_CYC   = FIFO_RST_DEF
) (
   input  logic       clk_32k,
   input  logic       rst_32k_alon_n,
   input  logic       rg_top_start,
   input  logic       rg_slot_en,
   input  logic       fifo_flush_req,
   input  logic       efuse_done,
   output logic       osc13m_clk_en,
   output logic       efuse_clk_en,
   output logic       timer_clk_en,
   output logic       data_clk_en,
   output logic       slot_clk_en,
   output logic       shut_rstn,
   output logic       pmu_fifo_rstn,
   output logic       efuse_load_start,
   output logic       efuse_err,
   output logic [2:0] pmu_state,
   output logic       pmu_busy
);
   localparam int CW = cnt_w(OSC_SETTLE_CYC, EFUSE_TMO_CYC, SHUT_HOLD_CYC, FIFO_RST_CYC);
   pmu_state_e st, ns;
   logic          zero, f_zero, ld, f_ld, act, run;
   logic [CW-1:0] ld_val;
   always_comb begin
      ns = st;
      case (st)
         IDLE:      ns = rg_top_start ? OSC_ON : IDLE;
         OSC_ON:    ns = !rg_top_start ? STOP_CLK : zero ? RST_REL : OSC_ON;
         RST_REL:   ns = !rg_top_start ? STOP_CLK : EFUSE;
         EFUSE:     ns = !rg_top_start ? STOP_CLK : (efuse_done || zero) ? ACTIVE : EFUSE;
         ACTIVE:    ns = !rg_top_start ? STOP_CLK : ACTIVE;
         STOP_CLK:  ns = SHUT_HOLD;
         SHUT_HOLD: ns = zero ? IDLE : SHUT_HOLD;
         default:   ns = IDLE;
      endcase
   end
   assign ld     = ns != st && ns inside {OSC_ON, EFUSE, SHUT_HOLD};
   assign ld_val = ns == OSC_ON ? CW'(OSC_SETTLE_CYC - 1) :
                   ns == EFUSE  ? CW'(EFUSE_TMO_CYC - 1)  : CW'(SHUT_HOLD_CYC - 1);
   assign act    = st == ACTIVE && ns == ACTIVE;
   assign f_ld   = act && fifo_flush_req;
   assign run    = ns inside {RST_REL, EFUSE, ACTIVE};
   pmu_cnt #(.W(CW)) u_seq_cnt (
      .clk_32k        (clk_32k),
      .rst_32k_alon_n (rst_32k_alon_n),
      .load           (ld),
      .load_val       (ld_val),
      .zero           (zero)
   );
   pmu_cnt #(.W(CW)) u_fifo_cnt (
      .clk_32k        (clk_32k),
      .rst_32k_alon_n (rst_32k_alon_n),
      .load           (f_ld),
      .load_val       (CW'(FIFO_RST_CYC - 1)),
      .zero           (f_zero)
   );
   // STOP_CLK keeps timer/shut/fifo as they were so a stop from OSC_ON never raises them
   always_ff @(posedge clk_32k or negedge rst_32k_alon_n)
      if (!rst_32k_alon_n) begin
         st               <= IDLE;
         osc13m_clk_en    <= 1'b0;
         efuse_clk_en     <= 1'b0;
         timer_clk_en     <= 1'b0;
         data_clk_en      <= 1'b0;
         slot_clk_en      <= 1'b0;
         shut_rstn        <= 1'b0;
         pmu_fifo_rstn    <= 1'b0;
         efuse_load_start <= 1'b0;
         efuse_err        <= 1'b0;
         pmu_busy         <= 1'b0;
      end else begin
         st               <= ns;
         osc13m_clk_en    <= ns != IDLE;
         efuse_clk_en     <= ns inside {RST_REL, EFUSE};
         timer_clk_en     <= ns == ACTIVE || (ns == STOP_CLK && timer_clk_en);
         data_clk_en      <= ns == ACTIVE;
         slot_clk_en      <= ns == ACTIVE && rg_slot_en;
         shut_rstn        <= run || (ns == STOP_CLK && shut_rstn);
         pmu_fifo_rstn    <= act ? !fifo_flush_req && (pmu_fifo_rstn || f_zero) :
                             ns == STOP_CLK ? pmu_fifo_rstn : run;
         efuse_load_start <= ns == RST_REL;
         efuse_err        <= (st == EFUSE && efuse_done) ? 1'b0 :
                             (st == EFUSE && ns == ACTIVE) ? 1'b1 : efuse_err;
         pmu_busy         <= !(ns inside {IDLE, ACTIVE});
      end
   assign pmu_state = st;
endmodule

// File: tb/tb_pmu_seq.sv
// tb_pmu_seq: scoreboard bench; expected output vectors are queued with their due cycle as stimulus is driven
module tb_pmu_seq;
   logic clk_32k = 1'b0, rst_32k_alon_n = 1'b0;
   logic rg_top_start = 1'b1, rg_slot_en = 1'b1, fifo_flush_req = 1'b0, efuse_done = 1'b0;
   logic osc13m_clk_en, efuse_clk_en, timer_clk_en, data_clk_en, slot_clk_en;
   logic shut_rstn, pmu_fifo_rstn, efuse_load_start, efuse_err, pmu_busy;
   logic [2:0] pmu_state;
   logic [12:0] obs;
   int cyc = 0, n_chk = 0, n_err = 0;
   typedef struct {int at; string tag; logic [12:0] v;} exp_t;
   exp_t sb[$];
   localparam logic [12:0] OSC = 13'h001, EFC = 13'h002, TMR = 13'h004, DAT = 13'h008, SLT = 13'h010;
   localparam logic [12:0] SHR = 13'h020, FIF = 13'h040, LDS = 13'h080, ERR = 13'h100, BSY = 13'h200;
   localparam logic [12:0] OSV = OSC | BSY | (13'd1 << 10);
   localparam logic [12:0] RLV = OSC | EFC | SHR | FIF | LDS | BSY | (13'd2 << 10);
   localparam logic [12:0] EFV = OSC | EFC | SHR | FIF | BSY | (13'd3 << 10);
   localparam logic [12:0] ACT = OSC | TMR | DAT | SLT | SHR | FIF | (13'd4 << 10);
   localparam logic [12:0] STV = OSC | TMR | SHR | FIF | BSY | (13'd5 << 10);
   localparam logic [12:0] SHV = OSC | BSY | (13'd6 << 10);
   pmu_seq dut (
      .clk_32k          (clk_32k),
      .rst_32k_alon_n   (rst_32k_alon_n),
      .rg_top_start     (rg_top_start),
      .rg_slot_en       (rg_slot_en),
      .fifo_flush_req   (fifo_flush_req),
      .efuse_done       (efuse_done),
      .osc13m_clk_en    (osc13m_clk_en),
      .efuse_clk_en     (efuse_clk_en),
      .timer_clk_en     (timer_clk_en),
      .data_clk_en      (data_clk_en),
      .slot_clk_en      (slot_clk_en),
      .shut_rstn        (shut_rstn),
      .pmu_fifo_rstn    (pmu_fifo_rstn),
      .efuse_load_start (efuse_load_start),
      .efuse_err        (efuse_err),
      .pmu_state        (pmu_state),
      .pmu_busy         (pmu_busy)
   );
   assign obs = {pmu_state, pmu_busy, efuse_err, efuse_load_start, pmu_fifo_rstn, shut_rstn,
                 slot_clk_en, data_clk_en, timer_clk_en, efuse_clk_en, osc13m_clk_en};
   always #5 clk_32k = ~clk_32k;
   always @(posedge clk_32k) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h exp %h", tag, cyc, got, exp);
      end
   endtask
   always @(negedge clk_32k)
      for (int i = sb.size() - 1; i >= 0; i--)
         if (sb[i].at == cyc) begin
            chk(sb[i].tag, obs, sb[i].v);
            sb.delete(i);
         end
   task automatic push(input int at, input string tag, input logic [12:0] v);
      sb.push_back('{at, tag, v});
   endtask
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_32k);
         #1;
      end
   endtask
   task automatic to(input int c);
      while (cyc < c) tick();
   endtask
   initial begin
      int b, c, d, e, s, b2, s2, b3, b4, b5;
      tick(3);
      b = cyc;
      push(b, "rst_state", '0);
      push(b + 1, "osc_on", OSV);
      push(b + 16, "osc_last", OSV);
      push(b + 17, "rst_rel", RLV);
      push(b + 18, "efuse", EFV);
      push(b + 22, "efuse_wait", EFV);
      push(b + 23, "active", ACT);
      rst_32k_alon_n = 1'b1;
      to(b + 22); efuse_done = 1'b1; tick(); efuse_done = 1'b0;
      c = b + 25;
      push(c + 1, "flush1", ACT & ~FIF);
      push(c + 2, "flush2", ACT & ~FIF);
      push(c + 3, "flush_end", ACT);
      to(c); fifo_flush_req = 1'b1; tick(); fifo_flush_req = 1'b0;
      d = c + 5;
      push(d + 2, "reflush_a", ACT & ~FIF);
      push(d + 3, "reflush_b", ACT & ~FIF);
      push(d + 4, "reflush_end", ACT);
      to(d); fifo_flush_req = 1'b1; tick(2); fifo_flush_req = 1'b0;
      e = d + 6;
      push(e + 1, "slot_off", ACT & ~SLT);
      push(e + 2, "slot_on", ACT);
      to(e); rg_slot_en = 1'b0; tick(); rg_slot_en = 1'b1;
      s = e + 4;
      push(s + 1, "stop_clk", STV);
      push(s + 2, "shut_hold", SHV);
      push(s + 5, "shut_last", SHV);
      push(s + 6, "idle", '0);
      push(s + 7, "restart", OSV);
      to(s); rg_top_start = 1'b0;
      to(s + 3); rg_top_start = 1'b1;
      b2 = s + 6;
      push(b2 + 17, "tmo_rel", RLV);
      push(b2 + 81, "tmo_wait", EFV);
      push(b2 + 82, "tmo_active", ACT | ERR);
      push(b2 + 90, "err_sticky", ACT | ERR);
      to(b2 + 85); efuse_done = 1'b1; tick(); efuse_done = 1'b0;
      s2 = b2 + 92;
      push(s2 + 1, "stop_flush", STV | ERR);
      push(s2 + 2, "stop_flush_sh", SHV | ERR);
      push(s2 + 6, "idle_err", ERR);
      to(s2); rg_top_start = 1'b0; fifo_flush_req = 1'b1; tick(); fifo_flush_req = 1'b0;
      b3 = s2 + 8;
      push(b3 + 8, "osc_cnt8", OSV | ERR);
      push(b3 + 9, "osc_stop", OSC | BSY | ERR | (13'd5 << 10));
      push(b3 + 10, "osc_stop_sh", SHV | ERR);
      push(b3 + 14, "osc_stop_idle", ERR);
      to(b3); rg_top_start = 1'b1;
      to(b3 + 8); rg_top_start = 1'b0;
      b4 = b3 + 14;
      push(b4 + 20, "err_hold", EFV | ERR);
      push(b4 + 21, "err_clr", ACT);
      push(b4 + 23, "rst_active", '0);
      to(b4); rg_top_start = 1'b1;
      to(b4 + 20); efuse_done = 1'b1; tick(); efuse_done = 1'b0;
      to(b4 + 23); rst_32k_alon_n = 1'b0;
      tick(2);
      b5 = cyc;
      push(b5 + 19, "efuse5", EFV);
      push(b5 + 20, "rst_efuse", '0);
      push(b5 + 21, "rst_hold", '0);
      rst_32k_alon_n = 1'b1;
      to(b5 + 20); rst_32k_alon_n = 1'b0;
      tick(3);
      chk("sb_empty", 13'(sb.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
